// File: rtl/mmio_pkg.sv
// Shared MMIO register map: offsets, status bit positions and the offset decoder.
package mmio_pkg;

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    localparam int STATUS_TX_EMPTY = 0;
    localparam int STATUS_RX_AVAIL = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_STATUS,
        SEL_RXDATA,
        SEL_TXDATA,
        SEL_CYCLE,
        SEL_INSTR,
        SEL_CLEAR
    } reg_sel_t;

    function automatic reg_sel_t decode_offset(input logic [7:0] off);
        reg_sel_t sel;
        case (off)
            OFF_STATUS: sel = SEL_STATUS;
            OFF_RXDATA: sel = SEL_RXDATA;
            OFF_TXDATA: sel = SEL_TXDATA;
            OFF_CYCLE:  sel = SEL_CYCLE;
            OFF_INSTR:  sel = SEL_INSTR;
            OFF_CLEAR:  sel = SEL_CLEAR;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// IO-region peripheral block: status, UART rx FIFO, UART tx holding register,
// free-running cycle counter and retired-instruction counter.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    reg_sel_t                     sel;
    logic                         rd_req;
    logic                         wr_req;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic [7:0]                   fifo_head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(RX_FIFO_DEPTH):0] fifo_count;
    logic [31:0]                  rdata_d;
    logic [31:0]                  cycle_cnt;
    logic [31:0]                  instr_cnt;
    logic                         cnt_clear;
    logic                         unused_ok;

    assign sel       = decode_offset(req_addr[7:0]);
    assign rd_req    = req_valid && !req_we;
    assign wr_req    = req_valid && req_we;
    assign rx_ready  = !fifo_full;
    assign fifo_push = rx_valid && rx_ready;
    assign fifo_pop  = rd_req && (sel == SEL_RXDATA) && !fifo_empty;
    assign cnt_clear = wr_req && (sel == SEL_CLEAR);
    assign unused_ok = ^{req_addr[31:8], req_wdata[31:8], fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Load data selection from current-cycle state; write-only and unmapped offsets read 0.
    always_comb begin
        rdata_d = '0;
        case (sel)
            SEL_STATUS: begin
                rdata_d[STATUS_TX_EMPTY] = !tx_valid;
                rdata_d[STATUS_RX_AVAIL] = !fifo_empty;
            end
            SEL_RXDATA: rdata_d = fifo_empty ? 32'h0 : {24'h0, fifo_head};
            SEL_CYCLE:  rdata_d = cycle_cnt;
            SEL_INSTR:  rdata_d = instr_cnt;
            default:    rdata_d = '0;
        endcase
    end

    // Registered load data, held between loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_req) begin
            rdata <= rdata_d;
        end
    end

    // Tx holding register: accepts a byte only when empty, releases on handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end else if (wr_req && (sel == SEL_TXDATA) && !tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= req_wdata[7:0];
        end
    end

    // Performance counters; a clear store takes priority over increments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (cnt_clear) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retired) instr_cnt <= instr_cnt + 32'd1;
        end
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 RX_FIFO_DEPTH, 8, receive FIFO entries; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset); one clock, no other clock domains.
REQ-004 req_valid  input  1  memory stage is issuing an IO-region access this cycle.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address; only bits [7:0] decoded, caller guarantees IO region.
REQ-007 req_wdata  input  32  store data; tx uses [7:0].
REQ-008 rdata  output  32  load data, registered.
REQ-009 inst_retired  input  1  one-cycle pulse per retired (non-bubble) instruction.
REQ-010 rx_data / rx_valid / rx_ready  input 8 / input 1 / output 1  UART receiver byte stream.
REQ-011 tx_data / tx_valid / tx_ready  output 8 / output 1 / input 1  UART transmitter byte stream.

Function
REQ-012 Register map (offset from IO base): 0x00 status R, 0x04 rx data R, 0x08 tx data W, 0x10 cycle count R, 0x14 instruction count R, 0x18 counter clear W.
REQ-013 Status read: bit0 = tx holding register empty (!tx_valid), bit1 = rx FIFO non-empty, bits[31:2] = 0.
REQ-014 Load latency exactly 1 cycle: rdata updated on the edge after the req_valid && !req_we cycle, using state as it was during the request cycle; rdata holds its value otherwise.
REQ-015 Unmapped or write-only offsets read 0; stores to read-only or unmapped offsets have no effect.
REQ-016 Rx data read: rdata = {24'b0, FIFO head} and head popped; read while empty returns 0, no pop, pointers unchanged.
REQ-017 RX FIFO push when rx_valid && rx_ready; rx_ready = !full (combinational from count only); full FIFO backpressures UART, no byte lost or overwritten.
REQ-018 Simultaneous push and pop: both occur, count unchanged; with FIFO empty, the pop is suppressed (returns 0) and the push still lands.
REQ-019 FIFO pointers wrap modulo RX_FIFO_DEPTH; count width log2(DEPTH)+1; byte order strictly preserved.
REQ-020 Tx holding register: store to 0x08 while tx_valid = 0 loads req_wdata[7:0] and sets tx_valid next cycle; store while tx_valid = 1 is dropped.
REQ-021 tx_valid clears on the cycle after tx_valid && tx_ready; tx_data stable while tx_valid = 1.
REQ-022 Cycle counter: 32-bit, +1 every cycle out of reset, wraps 0xFFFF_FFFF -> 0.
REQ-023 Instruction counter: 32-bit, +1 per inst_retired pulse, wraps.
REQ-024 Store to 0x18 (any data): both counters = 0 on the next edge; clear wins over a same-cycle increment.
REQ-025 Counter read in the clear cycle returns the pre-clear value.

Reset
REQ-026 rst low: rdata = 0, tx_valid = 0, tx_data = 0, FIFO pointers and count = 0 (rx_ready = 1 once rst releases), both counters = 0.
REQ-027 Reset mid-transfer discards FIFO contents and any pending tx byte; no partial state survives.
REQ-028 Release synchronously to clk is the integrator's responsibility; block behaviour is defined only from the first edge after rst high.

Structure
REQ-029 Register offsets and status bit positions live in shared package mmio_pkg, also used by the CPU memory-stage decode.
REQ-030 RX FIFO is a separate sub-module, sync_fifo (parameterized WIDTH, DEPTH; push/pop/full/empty/count).
REQ-031 No combinational path from req_* to rdata; rx_ready depends only on FIFO state.

Verification
REQ-032 Reset then idle 100 cycles, read 0x10 -> rdata = 100 +/- 1 according to the documented sample point; read 0x00 -> 0x1.
REQ-033 Push 0x41, 0x42, 0x43 via rx, read 0x04 three times -> 0x41, 0x42, 0x43; fourth read -> 0, status bit1 = 0.
REQ-034 Push DEPTH+2 bytes with no reads -> rx_ready low after DEPTH, the last 2 held by UART; drain -> all DEPTH+2 in order.
REQ-035 Store 0x55 to 0x08 with tx_ready = 0 for 5 cycles, store 0x66 meanwhile -> tx_data = 0x55 stable, 0x66 dropped; tx_ready pulse -> tx_valid clears next cycle.
REQ-036 Pulse inst_retired 7 times, store to 0x18 in the same cycle as an 8th pulse -> both counters read 0 afterwards.
REQ-037 Assert rst low with 3 bytes queued and tx pending -> status reads 0x1 after release, rx reads return 0.
